// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display controller.
//   SEG_BLANK       active-low code with every segment off
//   SEG_TABLE       active-high 7-segment patterns for nibbles 0..F
//                   (bit 0 = segment a ... bit 6 = segment g)
//   DIGITS_MIN/MAX  legal range of the DIGITS parameter
//   DIV_MIN         smallest legal BLINK_DIV / SCAN_DIV
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 8;
  localparam int DIV_MIN    = 2;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Signal bundle for driving and observing one hex display controller.
//   value, load, digit_en, blink_mask, lz_blank : configuration toward the controller
//   seg, mux_seg, mux_sel                       : active-low display outputs
// master : the side that supplies configuration (a CPU shim or a bench)
// slave  : the controller side
// load is a single-cycle-or-longer strobe: every rising edge that sees
// load=1 captures the other configuration fields; there is no back-pressure.
interface hex_display_ctrl_if
  import hex_display_pkg::*;
#(
  parameter int DIGITS = 6
);

  logic [4*DIGITS-1:0] value;
  logic                load;
  logic [DIGITS-1:0]   digit_en;
  logic [DIGITS-1:0]   blink_mask;
  logic                lz_blank;
  logic [7*DIGITS-1:0] seg;
  logic [6:0]          mux_seg;
  logic [DIGITS-1:0]   mux_sel;

  modport master (
    output value, load, digit_en, blink_mask, lz_blank,
    input  seg, mux_seg, mux_sel
  );

  modport slave (
    input  value, load, digit_en, blink_mask, lz_blank,
    output seg, mux_seg, mux_sel
  );

endinterface

// File: rtl/hex_seg_decode.sv
// Combinational nibble to 7-segment decoder, active-high.
//   nibble : hex value 0..F
//   seg    : segments a..g in bits 0..6, 1 = lit
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// Hex display controller: captures a multi-digit hex value with per-digit
// enable, blink and leading-zero blanking, and drives both a static
// per-digit segment bus and a time-multiplexed single-digit bus.
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   value_i      nibble k = digit k, digit 0 least significant
//   load_i       capture strobe for value/enables/masks/lz flag
//   digit_en_i   per-digit enable
//   blink_mask_i per-digit blink select
//   lz_blank_i   leading-zero blanking enable
//   seg_o        static segments, active-low, 7 bits per digit
//   mux_seg_o    multiplexed segments, active-low
//   mux_sel_o    multiplexed digit select, active-low, one-cold
// Pipeline: capture regs -> seg_stage -> seg_o, so a load shows on seg_o
// two edges after the capturing edge.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25000000,
  parameter int SCAN_DIV  = 50000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [4*DIGITS-1:0] value_i,
  input  logic                load_i,
  input  logic [DIGITS-1:0]   digit_en_i,
  input  logic [DIGITS-1:0]   blink_mask_i,
  input  logic                lz_blank_i,
  output logic [7*DIGITS-1:0] seg_o,
  output logic [6:0]          mux_seg_o,
  output logic [DIGITS-1:0]   mux_sel_o
);

  // ---------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------
  if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_bad_digits
    $error("hex_display_ctrl: DIGITS must be in 1..8");
  end
  if (BLINK_DIV < DIV_MIN) begin : g_bad_blink
    $error("hex_display_ctrl: BLINK_DIV must be at least 2");
  end
  if (SCAN_DIV < DIV_MIN) begin : g_bad_scan
    $error("hex_display_ctrl: SCAN_DIV must be at least 2");
  end

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [4*DIGITS-1:0] cap_value;
  logic [DIGITS-1:0]   cap_en;
  logic [DIGITS-1:0]   cap_mask;
  logic                cap_lz;

  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;
  logic [SW-1:0]       scan_cnt;
  logic [IW-1:0]       scan_idx;

  logic [7*DIGITS-1:0] seg_stage;

  // ---------------------------------------------------------------------
  // Per-digit decode
  // ---------------------------------------------------------------------
  logic [6:0] seg_hi [DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    hex_seg_decode u_dec (
      .nibble (cap_value[4*g +: 4]),
      .seg    (seg_hi[g])
    );
  end

  // Blanking and inversion. zero_run walks from the top digit down and
  // stays set while every nibble seen so far is zero; enables play no part.
  logic [7*DIGITS-1:0] seg_next;
  logic                zero_run;
  logic                blank;

  always_comb begin
    seg_next = '1;
    zero_run = 1'b1;
    blank    = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (cap_value[4*k +: 4] == 4'h0);
      blank    = !cap_en[k]
               || (blink_phase && cap_mask[k])
               || (cap_lz && zero_run && (k != 0));
      seg_next[7*k +: 7] = blank ? SEG_BLANK : ~seg_hi[k];
    end
  end

  // ---------------------------------------------------------------------
  // Blink timebase
  // ---------------------------------------------------------------------
  logic [BW-1:0] blink_cnt_nxt;
  logic          blink_phase_nxt;

  always_comb begin
    blink_cnt_nxt   = blink_cnt + 1'b1;
    blink_phase_nxt = blink_phase;
    if (blink_cnt == BLINK_LAST) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = ~blink_phase;
    end
  end

  // ---------------------------------------------------------------------
  // Scan timebase and multiplexed outputs.
  // The mux outputs are registered from the *next* counter values so that
  // the registered select always matches the registered scan position; the
  // segment field is taken from seg_stage, which becomes seg_o on the same
  // edge, keeping mux_seg_o identical to the selected seg_o field.
  // ---------------------------------------------------------------------
  logic [SW-1:0]     scan_cnt_nxt;
  logic [IW-1:0]     scan_idx_nxt;
  logic [DIGITS-1:0] mux_sel_nxt;
  logic [6:0]        mux_seg_nxt;

  always_comb begin
    scan_cnt_nxt = scan_cnt + 1'b1;
    scan_idx_nxt = scan_idx;
    if (scan_cnt == SCAN_LAST) begin
      scan_cnt_nxt = '0;
      scan_idx_nxt = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end
  end

  always_comb begin
    mux_sel_nxt = '1;
    mux_seg_nxt = SEG_BLANK;
    // Count value 0 is the dead cycle of each slot: nothing selected.
    if (scan_cnt_nxt != '0) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (scan_idx_nxt == IW'(k)) begin
          mux_sel_nxt[k] = 1'b0;
          mux_seg_nxt    = seg_stage[7*k +: 7];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap_value   <= '0;
      cap_en      <= '0;
      cap_mask    <= '0;
      cap_lz      <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      scan_cnt    <= '0;
      scan_idx    <= '0;
      seg_stage   <= '1;
      seg_o       <= '1;
      mux_seg_o   <= SEG_BLANK;
      mux_sel_o   <= '1;
    end else begin
      if (load_i) begin
        cap_value <= value_i;
        cap_en    <= digit_en_i;
        cap_mask  <= blink_mask_i;
        cap_lz    <= lz_blank_i;
      end
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      scan_cnt    <= scan_cnt_nxt;
      scan_idx    <= scan_idx_nxt;
      seg_stage   <= seg_next;
      seg_o       <= seg_stage;
      mux_seg_o   <= mux_seg_nxt;
      mux_sel_o   <= mux_sel_nxt;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl (DIGITS=6, BLINK_DIV=4, SCAN_DIV=3).
// A posedge process pushes the expected seg_o for two edges later into
// exp_q; a negedge process pops it and checks seg_o, mux_sel_o, mux_seg_o.
module tb_hex_display_ctrl;

  localparam int DIGITS    = 6;
  localparam int BLINK_DIV = 4;
  localparam int SCAN_DIV  = 3;
  localparam int SEGW      = 7 * DIGITS;

  // Active-low codes for nibbles 0..F.
  localparam logic [6:0] LOW_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  hex_display_ctrl_if #(.DIGITS(DIGITS)) dif ();

  hex_display_ctrl #(
    .DIGITS    (DIGITS),
    .BLINK_DIV (BLINK_DIV),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .value_i      (dif.value),
    .load_i       (dif.load),
    .digit_en_i   (dif.digit_en),
    .blink_mask_i (dif.blink_mask),
    .lz_blank_i   (dif.lz_blank),
    .seg_o        (dif.seg),
    .mux_seg_o    (dif.mux_seg),
    .mux_sel_o    (dif.mux_sel)
  );

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Expected static segment word from spec-level rules.
  function automatic logic [SEGW-1:0] model_seg(
    input logic [4*DIGITS-1:0] v, input logic [DIGITS-1:0] en,
    input logic [DIGITS-1:0] mask, input logic lz, input logic phase);
    logic [SEGW-1:0] r;
    logic [4*DIGITS-1:0] upper;
    logic b;
    r = '1;
    for (int d = 0; d < DIGITS; d++) begin
      upper = v >> (4 * d);
      b = !en[d] || (phase && mask[d]) || (lz && (d > 0) && (upper == '0));
      r[7*d +: 7] = b ? 7'h7F : LOW_TABLE[v[4*d +: 4]];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  logic [SEGW-1:0]     exp_q [$];
  logic                mon_en = 1'b0;
  int                  k = 0;          // edges since reset release
  logic [4*DIGITS-1:0] m_value = '0;
  logic [DIGITS-1:0]   m_en = '0;
  logic [DIGITS-1:0]   m_mask = '0;
  logic                m_lz = 1'b0;

  always @(posedge clk) begin
    if (mon_en) begin
      k++;
      if (dif.load) begin
        m_value = dif.value;
        m_en    = dif.digit_en;
        m_mask  = dif.blink_mask;
        m_lz    = dif.lz_blank;
      end
      exp_q.push_back(model_seg(m_value, m_en, m_mask, m_lz, ((k / BLINK_DIV) % 2) == 1));
    end
  end

  always @(negedge clk) begin
    logic [SEGW-1:0]   e;
    logic              dead;
    int                idx;
    logic [DIGITS-1:0] exp_sel;
    if (mon_en && k > 0) begin
      e = '1;
      if (exp_q.size() == 0) chk("exp_q_underflow", 64'd0, 64'd1);
      else e = exp_q.pop_front();
      chk("seg", 64'(dif.seg), 64'(e));
      dead = (k % SCAN_DIV) == 0;
      idx  = (k / SCAN_DIV) % DIGITS;
      exp_sel = dead ? {DIGITS{1'b1}} : ~(DIGITS'(1) << idx);
      chk("mux_sel", 64'(dif.mux_sel), 64'(exp_sel));
      chk("mux_seg", 64'(dif.mux_seg), dead ? 64'h7F : 64'(e[7*idx +: 7]));
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  // Called at a negedge; asserts reset a little later, checks the outputs
  // went blank at once, then releases two cycles later.
  task automatic do_reset();
    #1;
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst_seg", 64'(dif.seg), 64'h3FFFFFFFFFF);
    chk("rst_mux_sel", 64'(dif.mux_sel), 64'h3F);
    chk("rst_mux_seg", 64'(dif.mux_seg), 64'h7F);
    repeat (2) @(negedge clk);
    #1;
    exp_q.delete();
    exp_q.push_back('1);
    exp_q.push_back('1);
    k = 0;
    m_value = '0; m_en = '0; m_mask = '0; m_lz = 1'b0;
    resetn = 1'b1;
    mon_en = 1'b1;
    #1;
    chk("rel_mux_sel", 64'(dif.mux_sel), 64'h3F);
  endtask

  task automatic load_cfg(input logic [4*DIGITS-1:0] v, input logic [DIGITS-1:0] en,
                          input logic [DIGITS-1:0] mask, input logic lz, input int n);
    @(negedge clk);
    dif.value      = v;
    dif.digit_en   = en;
    dif.blink_mask = mask;
    dif.lz_blank   = lz;
    dif.load       = 1'b1;
    repeat (n) @(negedge clk);
    dif.load       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    logic found;
    resetn         = 1'b0;
    dif.value      = '0;
    dif.load       = 1'b0;
    dif.digit_en   = '0;
    dif.blink_mask = '0;
    dif.lz_blank   = 1'b0;

    @(negedge clk);
    do_reset();
    idle(5);

    // Decode, leading-zero blanking, zero value.
    load_cfg(24'h01A2F0, 6'h3F, 6'h00, 1'b0, 1); idle(6);
    load_cfg(24'h01A2F0, 6'h3F, 6'h00, 1'b1, 1); idle(6);
    load_cfg(24'h000000, 6'h3F, 6'h00, 1'b1, 1); idle(6);
    load_cfg(24'h000000, 6'h3F, 6'h00, 1'b0, 1); idle(4);
    load_cfg(24'h89ABCD, 6'h2D, 6'h00, 1'b0, 1); idle(4);
    load_cfg(24'h003456, 6'h3F, 6'h00, 1'b1, 1); idle(4);

    // Random configurations, some held for several recapture cycles.
    for (int i = 0; i < 6; i++) begin
      load_cfg(24'($urandom()), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
               1'($urandom_range(0, 1)), $urandom_range(1, 3));
      idle($urandom_range(2, 6));
    end

    // Blink on digit 0, then a long held load spanning blink wraps.
    load_cfg(24'h01A2F0, 6'h3F, 6'h01, 1'b0, 1); idle(20);
    load_cfg(24'h7E5A10, 6'h3F, 6'h3F, 1'b0, 9); idle(12);

    // Mid-operation reset at blink_phase=1, scan index 3.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (((k / BLINK_DIV) % 2 == 1) && ((k / SCAN_DIV) % DIGITS == 3)) found = 1'b1;
    end
    chk("mid_rst_reach", 64'(found), 64'd1);
    do_reset();
    idle(20);
    load_cfg(24'h00C0DE, 6'h3F, 6'h04, 1'b1, 1); idle(24);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global guard so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 Parameter DIGITS, default 6: number of hex digits; legal range 1..8.
REQ-002 Parameter BLINK_DIV, default 25000000: clock cycles per blink half-period; minimum 2.
REQ-003 Parameter SCAN_DIV, default 50000: clock cycles per scan slot in multiplexed output; minimum 2.
REQ-004 Ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- value_i  in  4*DIGITS  nibble k is the value for digit k; digit 0 is least significant.
- load_i  in  1  capture strobe.
- digit_en_i  in  DIGITS  per-digit enable.
- blink_mask_i  in  DIGITS  per-digit blink select.
- lz_blank_i  in  1  leading-zero blanking enable.
- seg_o  out  7*DIGITS  static segment outputs, active-low; bits 7k+0..7k+6 drive segments a..g of digit k.
- mux_seg_o  out  7  multiplexed segment bus, active-low.
- mux_sel_o  out  DIGITS  multiplexed digit select, active-low, one-cold.

Function
REQ-005 When load_i=1 on a rising edge, the block SHALL capture value_i, digit_en_i, blink_mask_i and lz_blank_i into internal registers; holding load_i high SHALL recapture every cycle.
REQ-006 seg_o SHALL be registered and SHALL reflect newly captured data on the second rising edge after the capturing edge, giving a fixed 2-cycle latency.
REQ-007 Per-digit code SHALL be the active-low inverse of the active-high hex table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=67 A=77 B=7C C=39 D=5E E=79 F=71.
REQ-008 A blanked digit SHALL output 7'h7F, with all segments off.
REQ-009 Digit k SHALL be blanked if any of the following holds: digit_en bit k=0; blink_phase=1 and blink_mask bit k=1; or it is a leading zero.
REQ-010 Leading zero: with lz_blank=1, digit k (k>0) SHALL be blanked when its nibble and all nibbles above it are 0. Digit 0 SHALL never be blanked by leading-zero logic. Leading-zero evaluation SHALL use nibble values only, independent of enables.
REQ-011 Blink counter SHALL count 0..BLINK_DIV-1 and wrap to 0. On each wrap, blink_phase SHALL toggle. Load SHALL NOT affect the counter or the phase. A load coinciding with a wrap SHALL apply both effects.
REQ-012 Scan index SHALL advance 0..DIGITS-1 and wrap to 0. Each index SHALL occupy one slot of SCAN_DIV cycles.
REQ-013 In the first cycle of each slot, mux_sel_o SHALL be all ones (dead time). In the remaining SCAN_DIV-1 cycles, only the bit of the current index SHALL be 0.
REQ-014 mux_seg_o SHALL equal the 7-bit field of seg_o for the current index. It SHALL be registered in the same cycle as mux_sel_o, so the two are always aligned. During dead time, mux_seg_o SHALL be 7'h7F.
REQ-015 Static and multiplexed outputs SHALL be active simultaneously. The board selects which to wire.

Reset
REQ-016 resetn=0 SHALL asynchronously set:
- seg_o all ones, mux_seg_o=7'h7F, mux_sel_o all ones.
- captured value and mask registers to 0, so all digits are disabled.
- blink counter=0, blink_phase=0, scan counter=0, scan index=0.
REQ-017 After release, the first scan slot SHALL be index 0 starting with its dead cycle. All digits SHALL stay blank until the first load.
REQ-018 Reset asserted mid-slot or mid-blink SHALL discard all progress; no partial state survives.

Structure
REQ-019 Package hex_display_pkg SHALL hold SEG_BLANK (7'h7F), the 16-entry active-high segment table, and parameter-range check constants.
REQ-020 Sub-module hex_seg_decode (4-bit in, 7-bit active-high out, combinational) SHALL be instantiated DIGITS times via generate. The top level SHALL own all registers, counters and inversion.
REQ-021 Illegal parameter values SHALL cause an elaboration-time error.

Verification (DIGITS=6, BLINK_DIV=4, SCAN_DIV=3)
REQ-022 Reset: hold resetn=0 -> seg_o=42'h3FFFFFFFFFF, mux_sel_o=6'h3F, mux_seg_o=7'h7F.
REQ-023 Decode: load value 24'h01A2F0 with en=6'h3F, lz=0 -> two edges later, digits 0..5 read 40,0E,24,08,79,40.
REQ-024 Leading zero:
- Same load with lz=1 -> digit5=7F, digit4=79.
- Value 0, lz=1 -> digits 1..5 read 7F, digit0 reads 40.
REQ-025 Blink: mask=6'h01 -> digit0 alternates 40/7F every 4 cycles; digits 1..5 stay steady. A load on a wrap cycle keeps the toggle cadence.
REQ-026 Scan:
- mux_sel_o sequence: 3F, 3E, 3E, 3F, 3D, 3D, ... 3F, 1F, 1F, then wraps to index 0.
- Whenever mux_sel_o=3E, mux_seg_o equals seg_o[6:0].
REQ-027 Mid-operation reset: pulse resetn low at blink_phase=1, scan index 3 -> all outputs blank immediately. After release, index 0 dead cycle first and blink_phase=0.
